// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and frame-length helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Bit periods from the first tick of a frame to its done tick
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// rtl/uart_tick_detect.sv - one-clock tick on each rising edge of the synchronous baud clock
module uart_tick_detect (
    input  logic clock,
    input  logic reset,
    input  logic u_clk,
    output logic tick
);

    logic u_clk_prev;

    // Reset to 1 so a baud clock that is already high after reset is not seen as an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            u_clk_prev <= 1'b1;
        end else begin
            u_clk_prev <= u_clk;
        end
    end

    assign tick = u_clk & ~u_clk_prev;

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer driven by baud-clock ticks
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS = 8,
    parameter int P_PARITY    = 0,
    parameter int P_STOP_BITS = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_u_clk,
    input  logic [P_DATA_BITS-1:0] i_tx_data,
    input  logic                   i_tx_valid,
    output logic                   o_tx_ready,
    output logic                   o_uart_tx,
    output logic                   o_tx_busy,
    output logic                   o_tx_done
);

    localparam int             CW         = $clog2(P_DATA_BITS + 1);
    localparam bit             HAS_PARITY = (P_PARITY == PAR_ODD) || (P_PARITY == PAR_EVEN);
    localparam logic [CW-1:0]  DATA_LAST  = CW'(P_DATA_BITS - 1);
    localparam logic [CW-1:0]  STOP_LAST  = CW'(P_STOP_BITS - 1);

    uart_state_t            state, state_next;
    logic [P_DATA_BITS-1:0] shift, shift_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   par, par_next;
    logic                   line_next, ready_next, busy_next, done_next;
    logic                   tick;

    uart_tick_detect u_tick_detect (
        .clock (clock),
        .reset (reset),
        .u_clk (i_u_clk),
        .tick  (tick)
    );

    always_comb begin
        state_next = state;
        shift_next = shift;
        cnt_next   = cnt;
        par_next   = par;
        line_next  = o_uart_tx;
        ready_next = o_tx_ready;
        busy_next  = o_tx_busy;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (i_tx_valid && o_tx_ready) begin
                    shift_next = i_tx_data;
                    par_next   = (^i_tx_data) ^ (P_PARITY == PAR_ODD);
                    cnt_next   = '0;
                    state_next = START;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                // Line still high means the start bit has not begun yet
                if (tick) begin
                    if (o_uart_tx) begin
                        line_next = 1'b0;
                    end else begin
                        line_next  = shift[0];
                        shift_next = shift >> 1;
                        cnt_next   = '0;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt == DATA_LAST) begin
                        cnt_next = '0;
                        if (HAS_PARITY) begin
                            line_next  = par;
                            state_next = PARITY;
                        end else begin
                            line_next  = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        line_next  = shift[0];
                        shift_next = shift >> 1;
                        cnt_next   = cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    line_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt == STOP_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        ready_next = 1'b1;
                        line_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            o_uart_tx  <= 1'b1;
            o_tx_ready <= 1'b1;
            o_tx_busy  <= 1'b0;
            o_tx_done  <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            cnt        <= cnt_next;
            par        <= par_next;
            o_uart_tx  <= line_next;
            o_tx_ready <= ready_next;
            o_tx_busy  <= busy_next;
            o_tx_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int NI = 4;
    localparam int PAR_CFG  [NI] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    localparam int STOP_CFG [NI] = '{1, 1, 1, 2};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          u_clk = 1'b0;
    logic          u_run = 1'b1;
    logic [NI-1:0] valid = '0;
    logic [7:0]    data [NI];
    wire  [NI-1:0] line, ready, busy, done;

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_serializer #(
            .P_DATA_BITS (8),
            .P_PARITY    (PAR_CFG[g]),
            .P_STOP_BITS (STOP_CFG[g])
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .i_u_clk    (u_clk),
            .i_tx_data  (data[g]),
            .i_tx_valid (valid[g]),
            .o_tx_ready (ready[g]),
            .o_uart_tx  (line[g]),
            .o_tx_busy  (busy[g]),
            .o_tx_done  (done[g])
        );
    end

    always #5 clock = ~clock;

    // Baud generator, divide by 16
    initial begin
        int bcnt;
        bcnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (u_run) begin
                bcnt  = (bcnt + 1) % 16;
                u_clk = (bcnt >= 8);
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Frame-level model: each accepted byte becomes a list of line bits, one per tick
    logic        m_line [NI];
    logic        m_ready[NI];
    logic        m_busy [NI];
    logic        m_done [NI];
    bit          m_active[NI];
    logic [15:0] m_frame[NI];
    int          m_idx  [NI];
    int          m_len  [NI];

    initial begin
        bit m_prev, tk, rdy_old;
        for (int k = 0; k < NI; k++) begin
            m_line[k] = 1'b1; m_ready[k] = 1'b1; m_busy[k] = 1'b0; m_done[k] = 1'b0;
            m_active[k] = 1'b0; m_idx[k] = 0; m_len[k] = 0; m_frame[k] = '1;
        end
        m_prev = 1'b1;
        forever begin
            @(posedge clock);
            tk     = u_clk && !m_prev;
            m_prev = reset ? 1'b1 : u_clk;
            for (int k = 0; k < NI; k++) begin
                if (reset) begin
                    m_line[k] = 1'b1; m_ready[k] = 1'b1; m_busy[k] = 1'b0;
                    m_done[k] = 1'b0; m_active[k] = 1'b0;
                end else begin
                    rdy_old   = m_ready[k];
                    m_done[k] = 1'b0;
                    if (tk && m_active[k]) begin
                        if (m_idx[k] < m_len[k]) begin
                            m_line[k] = m_frame[k][m_idx[k]];
                            m_idx[k]++;
                        end else begin
                            m_done[k] = 1'b1; m_ready[k] = 1'b1; m_busy[k] = 1'b0;
                            m_active[k] = 1'b0; m_line[k] = 1'b1;
                        end
                    end
                    if (valid[k] && rdy_old) begin
                        m_frame[k]    = '1;
                        m_frame[k][0] = 1'b0;
                        for (int b = 0; b < 8; b++) m_frame[k][1+b] = data[k][b];
                        if (PAR_CFG[k] != PAR_NONE)
                            m_frame[k][9] = (^data[k]) ^ (PAR_CFG[k] == PAR_ODD);
                        m_len[k]    = frame_bits(8, PAR_CFG[k], STOP_CFG[k]);
                        m_idx[k]    = 0;
                        m_active[k] = 1'b1;
                        m_ready[k]  = 1'b0;
                        m_busy[k]   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            for (int k = 0; k < NI; k++) begin
                chk("line",  k, 32'(line[k]),  32'(m_line[k]));
                chk("ready", k, 32'(ready[k]), 32'(m_ready[k]));
                chk("busy",  k, 32'(busy[k]),  32'(m_busy[k]));
                chk("done",  k, 32'(done[k]),  32'(m_done[k]));
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, output bit ok);
        int n;
        @(posedge clock); #1;
        valid[k] = 1'b1;
        data[k]  = d;
        n = 0;
        do begin @(negedge clock); n++; end while (ready[k] && n < 50);
        ok = !ready[k];
        @(posedge clock); #1;
        valid[k] = 1'b0;
    endtask

    // Samples the line mid-bit from the start-bit fall; dur = clocks from fall to done
    task automatic rx_frame(input int k, output logic [31:0] bits, output int dur, output bit ok);
        int n;
        bits = '1;
        ok   = 1'b1;
        n    = 0;
        while (line[k] && n < 2000) begin @(negedge clock); n++; end
        if (line[k]) ok = 1'b0;
        n = 0;
        while (ok && !done[k] && n < 400) begin
            if ((n % 16) == 8 && (n / 16) < 32) bits[n/16] = line[k];
            @(negedge clock);
            n++;
        end
        if (!done[k]) ok = 1'b0;
        dur = n;
    endtask

    initial begin
        logic [31:0] bits, bits2;
        int          dur, dur2, seen;
        bit          ok, ok2;
        for (int k = 0; k < NI; k++) data[k] = 8'h00;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_line",  0, 32'(line[0]),  32'd1);
        chk("rst_ready", 0, 32'(ready[0]), 32'd1);
        chk("rst_busy",  0, 32'(busy[0]),  32'd0);
        chk("rst_done",  0, 32'(done[0]),  32'd0);

        send(0, 8'hA5, ok);
        chk("a5_accept", 0, 32'(ok), 32'd1);
        rx_frame(0, bits, dur, ok);
        chk("a5_frame_ok", 0, 32'(ok), 32'd1);
        chk("a5_bits", 0, 32'(bits[9:0]), 32'h34A);
        chk("a5_dur", 0, dur, 160);

        send(1, 8'h07, ok);
        rx_frame(1, bits, dur, ok);
        chk("even_ok", 1, 32'(ok), 32'd1);
        chk("even_par", 1, 32'(bits[9]), 32'd1);
        chk("even_dur", 1, dur, 176);

        send(2, 8'h07, ok);
        rx_frame(2, bits, dur, ok);
        chk("odd_ok", 2, 32'(ok), 32'd1);
        chk("odd_par", 2, 32'(bits[9]), 32'd0);
        chk("odd_data", 2, 32'(bits[8:1]), 32'h07);
        chk("odd_dur", 2, dur, 176);

        send(3, 8'hFF, ok);
        rx_frame(3, bits, dur, ok);
        chk("stop2_ok", 3, 32'(ok), 32'd1);
        chk("stop2_tail", 3, 32'(bits[10:9]), 32'd3);
        chk("stop2_dur", 3, dur, 176);

        // Back-to-back with valid held, plus a mid-frame value that must be ignored
        @(posedge clock); #1;
        valid[0] = 1'b1;
        data[0]  = 8'h11;
        seen = 0;
        while (ready[0] && seen < 50) begin @(negedge clock); seen++; end
        @(posedge clock); #1 data[0] = 8'h22;
        rx_frame(0, bits, dur, ok);
        @(posedge clock); #1 valid[0] = 1'b0;
        fork
            rx_frame(0, bits2, dur2, ok2);
            begin
                repeat (40) @(posedge clock);
                #1 valid[0] = 1'b1; data[0] = 8'h33;
                repeat (5) @(posedge clock);
                #1 valid[0] = 1'b0;
            end
        join
        chk("b2b_first_ok", 0, 32'(ok), 32'd1);
        chk("b2b_first", 0, 32'(bits[8:1]), 32'h11);
        chk("b2b_second_ok", 0, 32'(ok2), 32'd1);
        chk("b2b_second", 0, 32'(bits2[8:1]), 32'h22);
        repeat (40) @(negedge clock);

        // Abort during data bit 3 of 0x55
        send(0, 8'h55, ok);
        seen = 0;
        while (line[0] && seen < 100) begin @(negedge clock); seen++; end
        chk("abort_start", 0, 32'(line[0]), 32'd0);
        repeat (16 * 4 + 8) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_line",  0, 32'(line[0]),  32'd1);
        chk("abort_ready", 0, 32'(ready[0]), 32'd1);
        chk("abort_busy",  0, 32'(busy[0]),  32'd0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (done[0] || !line[0]) seen++;
            @(negedge clock);
        end
        chk("abort_quiet", 0, seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
